// File: rtl/alu_arbiter.sv
// Two-requester front end to one shared 32-bit ALU, with one registered response slot per requester.
// Ties go round robin; build with ALU_ARBITER_FIXED_PRIO_EN so that requester 0 wins every tie instead.
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_op,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_op,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  input  logic              rsp1_ready
);

  localparam int SH_W = $clog2(DATA_W);

  function automatic logic [DATA_W-1:0] alu_f(input logic [3:0]        op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa;
    logic signed [DATA_W-1:0] sb;
    logic [SH_W-1:0]          sh;
    sa = a;
    sb = b;
    sh = b[SH_W-1:0];
    case (op)
      4'b0000: alu_f = a + b;
      4'b0010: alu_f = a - b;
      4'b0001: alu_f = a | b;
      4'b0011: alu_f = a & b;
      4'b0100: alu_f = a << sh;
      4'b0101: alu_f = a >> sh;
      4'b1101: alu_f = DATA_W'(sa >>> sh);
      4'b1000: alu_f = a ^ b;
      4'b0110: alu_f = DATA_W'(sa < sb);
      4'b0111: alu_f = DATA_W'(a < b);
      default: alu_f = '0;
    endcase
  endfunction

  logic              elig0, elig1;
  logic              gnt0, gnt1;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_y;
  logic              alu_z;

  // A slot can take a new result if it is empty or is being drained this cycle.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  assign gnt0 = rst_n & elig0;
  assign gnt1 = rst_n & elig1 & ~elig0;
`else
  logic last_grant;

  assign gnt0 = rst_n & elig0 & (~elig1 | last_grant);
  assign gnt1 = rst_n & elig1 & (~elig0 | ~last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (gnt0) begin
      last_grant <= 1'b0;
    end else if (gnt1) begin
      last_grant <= 1'b1;
    end
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign alu_op = gnt1 ? req1_op : req0_op;
  assign alu_a  = gnt1 ? req1_a  : req0_a;
  assign alu_b  = gnt1 ? req1_b  : req0_b;
  assign alu_y  = alu_f(alu_op, alu_a, alu_b);
  assign alu_z  = (alu_y == '0);

  // Response registers: a new accept overrides a drain, so back-to-back results keep valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
    end else if (gnt0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_y;
      rsp0_zero   <= alu_z;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else if (gnt1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_y;
      rsp1_zero   <= alu_z;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed tables, corner sequences and a random run against a reference model.
// Define ALU_ARBITER_FIXED_PRIO_EN here too when the design is built with fixed priority.
module tb_alu_arbiter;

`ifdef ALU_ARBITER_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic        rsp0_ready, rsp1_ready;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_ready(rsp1_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: what each response slot should be holding, and who won the last tie.
  bit          m_vld[2];
  logic [31:0] m_res[2];
  bit          m_zero[2];
  int          m_last;
  int          last_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    longint      sa, sb;
    sh = b % 32;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0:    return a + b;
      4'd2:    return a - b;
      4'd1:    return a | b;
      4'd3:    return a & b;
      4'd4:    return 32'(longint'(a) * (longint'(1) << sh));
      4'd5:    return 32'(longint'(a) / (longint'(1) << sh));
      4'd13:   return 32'(sa >>> sh);
      4'd8:    return a ^ b;
      4'd6:    return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:    return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_vld[n]  = 1'b0;
      m_res[n]  = 32'd0;
      m_zero[n] = 1'b0;
    end
    m_last = 1;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return 1 ns after the rising edge.
  task automatic cyc();
    bit e0, e1;
    int g;
    @(negedge clk);
    e0 = req0_valid && (!m_vld[0] || rsp0_ready);
    e1 = req1_valid && (!m_vld[1] || rsp1_ready);
    g = -1;
    if (e0 && e1)  g = FIXED ? 0 : ((m_last == 0) ? 1 : 0);
    else if (e0)   g = 0;
    else if (e1)   g = 1;
    last_g = g;
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("rsp0_valid", 32'(rsp0_valid), 32'(m_vld[0]));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(m_vld[1]));
    chk("rsp0_result", rsp0_result, m_res[0]);
    chk("rsp1_result", rsp1_result, m_res[1]);
    chk("rsp0_zero", 32'(rsp0_zero), 32'(m_zero[0]));
    chk("rsp1_zero", 32'(rsp1_zero), 32'(m_zero[1]));
    if (rsp0_ready) m_vld[0] = 1'b0;
    if (rsp1_ready) m_vld[1] = 1'b0;
    if (g == 0) begin
      m_vld[0] = 1'b1; m_res[0] = ref_alu(req0_op, req0_a, req0_b); m_zero[0] = (m_res[0] == 0); m_last = 0;
    end else if (g == 1) begin
      m_vld[1] = 1'b1; m_res[1] = ref_alu(req1_op, req1_a, req1_b); m_zero[1] = (m_res[1] == 0); m_last = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req0_op = 0;
    req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t        tbl[9];
  int          tie_exp[4];
  logic [3:0]  ops[12] = '{4'd0, 4'd2, 4'd1, 4'd3, 4'd4, 4'd5, 4'd13, 4'd8, 4'd6, 4'd7, 4'd15, 4'd9};

  initial begin
    tbl[0] = '{4'b0000, 32'd5,          32'd7,  32'd12,         1'b0};
    tbl[1] = '{4'b1101, 32'h8000_0000,  32'd31, 32'hFFFF_FFFF,  1'b0};
    tbl[2] = '{4'b0100, 32'h0000_1234,  32'd32, 32'h0000_1234,  1'b0};
    tbl[3] = '{4'b0111, 32'hFFFF_FFFF,  32'd1,  32'd0,          1'b1};
    tbl[4] = '{4'b1111, 32'd77,         32'd3,  32'd0,          1'b1};
    tbl[5] = '{4'b0110, 32'hFFFF_FFFF,  32'd1,  32'd1,          1'b0};
    tbl[6] = '{4'b0010, 32'd3,          32'd5,  32'hFFFF_FFFE,  1'b0};
    tbl[7] = '{4'b1000, 32'h0000_00F0,  32'hFF, 32'h0000_000F,  1'b0};
    tbl[8] = '{4'b0101, 32'h8000_0000,  32'd4,  32'h0800_0000,  1'b0};
    tie_exp = FIXED ? '{0, 0, 0, 0} : '{0, 1, 0, 1};

    // Reset state, with a request pending to show ready is held low.
    idle_inputs();
    req0_valid = 1;
    rst_n = 0;
    model_reset();
    #1;
    chk("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("reset_rsp0_result", rsp0_result, 32'd0);
    chk("reset_req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1;
    req0_valid = 0;

    // Single ADD, drained immediately.
    req0_valid = 1; req0_op = 4'b0000; req0_a = 5; req0_b = 7;
    cyc();
    req0_valid = 0;
    chk("single_valid", 32'(rsp0_valid), 32'd1);
    chk("single_result", rsp0_result, 32'd12);
    chk("single_zero", 32'(rsp0_zero), 32'd0);
    cyc();
    chk("single_drained", 32'(rsp0_valid), 32'd0);

    // Tie sequence after a fresh reset.
    rst_n = 0; model_reset(); #1; rst_n = 1;
    req0_valid = 1; req0_op = 4'b0000; req0_a = 1; req0_b = 1;
    req1_valid = 1; req1_op = 4'b0001; req1_a = 8; req1_b = 2;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("tie_grant", 32'(last_g), 32'(tie_exp[i]));
    end
    idle_inputs();
    cyc();

    // Directed op table through requester 0.
    for (int i = 0; i < 9; i++) begin
      req0_valid = 1; req0_op = tbl[i].op; req0_a = tbl[i].a; req0_b = tbl[i].b;
      cyc();
      chk("tbl_result", rsp0_result, tbl[i].res);
      chk("tbl_zero", 32'(rsp0_zero), 32'(tbl[i].z));
    end
    idle_inputs();
    cyc();

    // Back-pressure on slot 0 does not stop requester 1.
    rsp0_ready = 0;
    req0_valid = 1; req0_op = 4'b0010; req0_a = 9; req0_b = 9;
    cyc();
    req0_op = 4'b0000; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_op = 4'b0110; req1_a = 32'hFFFF_FFFF; req1_b = 1;
    cyc();
    chk("bp_req0_stalled", 32'(last_g), 32'd1);
    req1_valid = 0;
    chk("bp_rsp0_result", rsp0_result, 32'd0);
    chk("bp_rsp0_zero", 32'(rsp0_zero), 32'd1);
    chk("bp_rsp1_result", rsp1_result, 32'd1);
    cyc();
    cyc();
    chk("bp_rsp0_held", 32'(rsp0_valid), 32'd1);
    rsp0_ready = 1;
    cyc();
    idle_inputs();
    cyc();
    cyc();

    // Back-to-back results on slot 0.
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1; req0_op = 4'b0000; req0_a = 32'(100 * (i + 1)); req0_b = 32'd1;
      cyc();
      chk("b2b_valid", 32'(rsp0_valid), 32'd1);
      chk("b2b_result", rsp0_result, 32'(100 * (i + 1) + 1));
    end
    idle_inputs();
    cyc();
    cyc();

    // Reset while slot 1 holds a result; the first tie afterwards goes to requester 0.
    rsp1_ready = 0;
    req1_valid = 1; req1_op = 4'b0000; req1_a = 4; req1_b = 4;
    cyc();
    req1_valid = 0;
    cyc();
    chk("hold_rsp1_valid", 32'(rsp1_valid), 32'd1);
    rst_n = 0; model_reset();
    #1;
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp1_result", rsp1_result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    rsp1_ready = 1;
    req0_valid = 1; req1_valid = 1;
    cyc();
    chk("post_rst_tie", 32'(last_g), 32'd0);
    idle_inputs();
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      req0_op = ops[$urandom_range(0, 11)];
      req1_op = ops[$urandom_range(0, 11)];
      req0_a = $urandom;
      req1_a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      req0_b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      req1_b = ($urandom_range(0, 1) == 0) ? req1_a : $urandom;
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, ports listed below clock and reset first.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_a, reqN_b  input  32 each  (N=0,1) operands.
REQ-006 reqN_op  input  4  (N=0,1) ALU operation code, decoded in REQ-013.
REQ-007 reqN_ready  output  1  (N=0,1) requester N accepted this cycle when reqN_valid is also high.
REQ-008 rspN_valid  output  1  (N=0,1) result for requester N held.
REQ-009 rspN_result  output  32  (N=0,1) registered ALU result.
REQ-010 rspN_zero  output  1  (N=0,1) registered flag, high when rspN_result is 0.
REQ-011 rspN_ready  input  1  (N=0,1) requester N consumes its response.

Function
REQ-012 The block SHALL own one shared combinational ALU and accept at most one request per cycle.
REQ-013 Op codes SHALL be: 0000 ADD, 0010 SUB, 0001 OR, 0011 AND, 0100 SLL, 0101 SRL, 1101 SRA, 1000 XOR, 0110 SLT signed, 0111 SLTU; shift amount b[4:0]; SLT/SLTU yield 32'd1 or 32'd0; any other code yields 0 with zero=1.
REQ-014 Requester N SHALL be eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1).
REQ-015 reqN_ready SHALL be high only for the granted eligible requester; it is combinational from valids, rsp state and the priority pointer.
REQ-016 One eligible requester SHALL be granted regardless of pointer.
REQ-017 Both eligible: grant SHALL go to the requester not recorded in last_grant (round robin).
REQ-018 last_grant SHALL update to the granted index only on an accepted transfer.
REQ-019 On accept, ALU output SHALL be written into rspN_result/rspN_zero at the same edge; rspN_valid SHALL rise the following cycle (latency 1).
REQ-020 rspN_valid SHALL stay high and rspN_result/rspN_zero SHALL stay stable until a cycle with rspN_ready=1.
REQ-021 rspN_ready=1 with rspN_valid=1 and a new accept for N in the same cycle: new result SHALL replace old, rspN_valid stays 1 (back-to-back, one result per cycle).
REQ-022 rspN_ready=1 with no new accept: rspN_valid SHALL clear next cycle; rspN_result SHALL hold its value.
REQ-023 rspN_ready while rspN_valid=0 SHALL have no effect.
REQ-024 A non-granted requester with valid high SHALL see ready=0 and SHALL keep its request; the block does not drop it.
REQ-025 Response slots SHALL be independent: a stalled rsp0 SHALL not block requester 1.

Reset
REQ-026 On rst_n low, immediately: rsp0_valid=rsp1_valid=0, rsp*_result=0, rsp*_zero=0, last_grant=1 (requester 0 wins the first tie).
REQ-027 Reset mid-operation SHALL discard held responses; no result is emitted after deassertion unless newly accepted.
REQ-028 reqN_ready SHALL be 0 while rst_n is low.

Configuration
REQ-029 Macro ALU_ARBITER_FIXED_PRIO_EN: defined -> requester 0 SHALL win every tie and last_grant is not implemented; undefined -> round robin per REQ-017/018.

Verification
REQ-030 Single op: req0 ADD a=5,b=7 one cycle, rsp0_ready=1 -> next cycle rsp0_valid=1, result=12, zero=0; following cycle rsp0_valid=0.
REQ-031 Tie, round robin: both valid continuously, rsp ready=1 -> grants 0,1,0,1...; with ALU_ARBITER_FIXED_PRIO_EN -> grants 0,0,0... with req1_ready never high.
REQ-032 Back-pressure: rsp0_ready=0 after req0 SUB 9-9 -> rsp0 holds result=0, zero=1; req0 second request stalls (ready=0) while req1 SLT a=-1,b=1 completes with result=1.
REQ-033 Back-to-back: req0 valid 3 cycles, rsp0_ready=1 -> three results on consecutive cycles, rsp0_valid never drops between them.
REQ-034 Ops/boundaries: SRA 0x80000000 by 31 -> 0xFFFFFFFF; SLL by b=32 -> shift 0, result=a; SLTU 0xFFFFFFFF<1 -> 0; op 1111 -> 0, zero=1.
REQ-035 Reset with rsp1_valid=1 held -> rsp1_valid=0 immediately; after release first tie grants requester 0.
